simt_register_file: RTL

// Per-core register file for all threads of a block: one lane per thread, NUM_REGS regs each, top 3 read-only.

---
 rtl/simt_register_file_pkg.sv | 32 +++
 rtl/simt_regfile_lane.sv | 116 +++++++++++
 rtl/simt_register_file.sv | 117 +++++++++++
 3 files changed

// File: rtl/simt_register_file_pkg.sv
// Shared constants for the SIMT register file: core FSM state codes that
// gate reads and writes, write-source selector codes, and the layout of the
// read-only special registers at the top of each lane's register space.
package simt_register_file_pkg;

  // Core FSM states that the register file reacts to.
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  // Write-back source selected by the decoder.
  typedef enum logic [1:0] {
    SRC_ALU      = 2'b00,
    SRC_MEMORY   = 2'b01,
    SRC_CONSTANT = 2'b10,
    SRC_SMEM     = 2'b11
  } reg_src_e;

  // The top three registers of every lane are read-only:
  //   NUM_REGS-3 : %blockIdx  (latched on block_start)
  //   NUM_REGS-2 : %blockDim  (constant, threads per block)
  //   NUM_REGS-1 : %threadIdx (constant, lane index)
  localparam int RO_REGS        = 3;
  localparam int OFS_BLOCK_IDX  = 3;
  localparam int OFS_BLOCK_DIM  = 2;
  localparam int OFS_THREAD_IDX = 1;

  // True when addr points at one of the read-only special registers.
  function automatic logic is_read_only(input int addr, input int num_regs);
    return (addr >= num_regs - RO_REGS);
  endfunction

endpackage

// File: rtl/simt_regfile_lane.sv
// One thread lane of the SIMT register file: general-purpose storage, the
// special read-only registers, the registered operand outputs and the
// arbitration between the LSU load return and the UPDATE-stage write.
module simt_regfile_lane
  import simt_register_file_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16,
  parameter int LANE_IDX  = 0,
  parameter int BLOCK_DIM = 4,
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lane_enable,
  input  logic                 block_start,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [AW-1:0]        rd_addr,
  input  logic [AW-1:0]        rs_addr,
  input  logic [AW-1:0]        rt_addr,
  input  logic                 reg_write_enable,
  input  logic [1:0]           reg_input_mux,
  input  logic [DATA_BITS-1:0] immediate,
  input  logic [DATA_BITS-1:0] alu_in,
  input  logic [DATA_BITS-1:0] smem_in,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DATA_BITS-1:0] wb_data,
  output logic [DATA_BITS-1:0] rs_out,
  output logic [DATA_BITS-1:0] rt_out
);

  localparam int NUM_FREE = NUM_REGS - RO_REGS;
  localparam int DEPTH    = 1 << AW;

  logic [DATA_BITS-1:0] free_q [NUM_FREE];
  logic [DATA_BITS-1:0] free_d [NUM_FREE];
  logic [DATA_BITS-1:0] block_idx_q, block_idx_d;
  logic [DATA_BITS-1:0] rs_q, rs_d;
  logic [DATA_BITS-1:0] rt_q, rt_d;

  // Full address-space view; addresses beyond NUM_REGS read as zero.
  logic [DATA_BITS-1:0] view [DEPTH];
  reg_src_e             src;
  logic                 upd_write;
  logic [DATA_BITS-1:0] upd_data;

  // Assemble the readable register image from storage and constants.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) view[i] = '0;
    for (int i = 0; i < NUM_FREE; i++) view[i] = free_q[i];
    view[NUM_REGS-OFS_BLOCK_IDX]  = block_idx_q;
    view[NUM_REGS-OFS_BLOCK_DIM]  = DATA_BITS'(BLOCK_DIM);
    view[NUM_REGS-OFS_THREAD_IDX] = DATA_BITS'(LANE_IDX);
  end

  // Select the UPDATE-stage write source; MEMORY never writes here because
  // load data arrives only through the scoreboarded LSU return path.
  always_comb begin
    src       = reg_src_e'(reg_input_mux);
    upd_write = 1'b0;
    upd_data  = '0;
    if (lane_enable && (core_state == CORE_UPDATE) && reg_write_enable &&
        !is_read_only(int'(rd_addr), NUM_REGS)) begin
      case (src)
        SRC_ALU:      begin upd_write = 1'b1; upd_data = alu_in;    end
        SRC_CONSTANT: begin upd_write = 1'b1; upd_data = immediate; end
        SRC_SMEM:     begin upd_write = 1'b1; upd_data = smem_in;   end
        default:      begin upd_write = 1'b0; upd_data = '0;        end
      endcase
    end
  end

  // Next-state for storage and operands. The UPDATE write is applied after
  // the load return so the younger instruction wins on a same-register
  // collision. Operand reads use the pre-edge image (no bypass).
  always_comb begin
    free_d      = free_q;
    block_idx_d = block_idx_q;
    rs_d        = rs_q;
    rt_d        = rt_q;

    if (wb_valid && (int'(wb_addr) < NUM_FREE))
      free_d[wb_addr] = wb_data;
    if (upd_write)
      free_d[rd_addr] = upd_data;

    if (block_start)
      block_idx_d = DATA_BITS'(block_id);

    if (lane_enable && (core_state == CORE_REQUEST)) begin
      rs_d = view[rs_addr];
      rt_d = view[rt_addr];
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FREE; i++) free_q[i] <= '0;
      block_idx_q <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
    end else begin
      free_q      <= free_d;
      block_idx_q <= block_idx_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
    end
  end

  assign rs_out = rs_q;
  assign rt_out = rt_q;

endmodule

// File: rtl/simt_register_file.sv
// Per-core SIMT register file: one lane per thread plus a single load
// scoreboard shared by all lanes. A load records its destination register
// and the set of lanes still owed data; each lane's LSU return retires its
// own bit, in any order, and the scheduler sees load_busy / hazard until the
// last lane has written back.
module simt_register_file
  import simt_register_file_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS         = 8,
  parameter int NUM_REGS          = 16,
  localparam int AW               = $clog2(NUM_REGS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [THREADS_PER_BLOCK-1:0]           thread_enable,
  input  logic                                   block_start,
  input  logic [7:0]                             block_id,
  input  logic [2:0]                             core_state,
  input  logic [AW-1:0]                          rd_addr,
  input  logic [AW-1:0]                          rs_addr,
  input  logic [AW-1:0]                          rt_addr,
  input  logic                                   reg_write_enable,
  input  logic [1:0]                             reg_input_mux,
  input  logic [DATA_BITS-1:0]                   immediate,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] alu_out,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] smem_out,
  input  logic                                   load_issue,
  input  logic [THREADS_PER_BLOCK-1:0]           lsu_wb_valid,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] lsu_out,
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rs_out,
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rt_out,
  output logic                                   load_busy,
  output logic                                   hazard,
  output logic                                   proto_err
);

  localparam int T = THREADS_PER_BLOCK;

  logic [T-1:0]  pending_mask_q, pending_mask_d;
  logic [AW-1:0] pending_rd_q, pending_rd_d;
  logic          proto_err_q, proto_err_d;
  logic [T-1:0]  wb_hit;

  // A return only counts on a lane that still owes data.
  assign wb_hit    = lsu_wb_valid & pending_mask_q;
  assign load_busy = |pending_mask_q;

  // Scoreboard next-state. An issue while busy (including the cycle of the
  // final return) is dropped and latched as a protocol error.
  always_comb begin
    pending_mask_d = pending_mask_q & ~wb_hit;
    pending_rd_d   = pending_rd_q;
    proto_err_d    = proto_err_q;
    if (load_issue) begin
      if (load_busy) begin
        proto_err_d = 1'b1;
      end else begin
        pending_rd_d   = rd_addr;
        pending_mask_d = is_read_only(int'(rd_addr), NUM_REGS) ? '0 : thread_enable;
      end
    end
  end

  // Scoreboard registers; reset discards any loads in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_mask_q <= '0;
      pending_rd_q   <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      pending_mask_q <= pending_mask_d;
      pending_rd_q   <= pending_rd_d;
      proto_err_q    <= proto_err_d;
    end
  end

  // Flag any operand or destination that aliases the outstanding load.
  always_comb begin
    hazard = load_busy &&
             ((rs_addr == pending_rd_q) || (rt_addr == pending_rd_q) ||
              (rd_addr == pending_rd_q));
  end

  assign proto_err = proto_err_q;

  for (genvar t = 0; t < T; t++) begin : g_lane
    simt_regfile_lane #(
      .DATA_BITS (DATA_BITS),
      .NUM_REGS  (NUM_REGS),
      .LANE_IDX  (t),
      .BLOCK_DIM (T),
      .AW        (AW)
    ) u_lane (
      .clk              (clk),
      .reset            (reset),
      .lane_enable      (thread_enable[t]),
      .block_start      (block_start),
      .block_id         (block_id),
      .core_state       (core_state),
      .rd_addr          (rd_addr),
      .rs_addr          (rs_addr),
      .rt_addr          (rt_addr),
      .reg_write_enable (reg_write_enable),
      .reg_input_mux    (reg_input_mux),
      .immediate        (immediate),
      .alu_in           (alu_out[t*DATA_BITS +: DATA_BITS]),
      .smem_in          (smem_out[t*DATA_BITS +: DATA_BITS]),
      .wb_valid         (wb_hit[t]),
      .wb_addr          (pending_rd_q),
      .wb_data          (lsu_out[t*DATA_BITS +: DATA_BITS]),
      .rs_out           (rs_out[t*DATA_BITS +: DATA_BITS]),
      .rt_out           (rt_out[t*DATA_BITS +: DATA_BITS])
    );
  end

endmodule
